seq_shifter8b: RTL

- Multi-cycle, handshaked counterpart to the combinational 8-bit barrel shifter: shifts one bit position per clock.
- Target: area-constrained paths where a full barrel mux is too large.
- Uses the same operand/amount/direction convention as the barrel shifter: `lr` = 0 shifts left, `lr` = 1 shifts right, so the two blocks are interchangeable and cross-checkable.
- Sits between a requesting controller (`start`/`done` handshake) and downstream datapath logic.

---
 rtl/seq_shifter8b.sv | 103 ++++++++++
 1 files changed

// File: rtl/seq_shifter8b.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_shifter8b : multi-cycle start/done shifter, one bit position per clk |
// | Optional rotate mode when SEQ_SHIFTER_ROTATE_EN is defined (adds rot).   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module seq_shifter8b #(
  parameter int WIDTH = 8,
  parameter int SW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [SW-1:0]    s,
  input  logic             lr,
`ifdef SEQ_SHIFTER_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [SW-1:0] C_ONE = {{(SW-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic             rot_q, rot_d;
  logic             fill_l, fill_r;

  // Fill bits are zero for logical shifts, the wrapped-out bit for rotates.
  always_comb begin
    fill_l = rot_q & y_q[WIDTH-1];
    fill_r = rot_q & y_q[0];
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    rot_d   = rot_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          y_d     = a;
          cnt_d   = s;
          dir_d   = lr;
`ifdef SEQ_SHIFTER_ROTATE_EN
          rot_d   = rot;
`else
          rot_d   = 1'b0;
`endif
          state_d = (s != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (dir_q) y_d = {fill_r, y_q[WIDTH-1:1]};
        else       y_d = {y_q[WIDTH-2:0], fill_l};
        cnt_d = cnt_q - C_ONE;
        if (cnt_q == C_ONE) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // done is registered so it is high exactly while the DONE state is held.
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      rot_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      rot_q   <= rot_d;
      done_q  <= done_d;
    end
  end

  assign y    = y_q;
  assign done = done_q;
  assign busy = (state_q != ST_IDLE);

endmodule
`default_nettype wire
